mux_logic_pipe: RTL and testbench
=================================

// Module: mux_logic_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-bit mux-built gate set. Applies one of
//  eight bitwise ops, selected per transaction by in_op, to two WIDTH-bit operands. Every
//  result bit comes from 2:1 mux cells (select = a bit, data = b / ~b / constants).
//  Two-stage valid/ready pipeline, zero/parity flags, transaction counter, sticky illegal-op flag.
// PARAMETERS
//  WIDTH  8   operand/result width, >=1
//  TAG_W  4   sideband tag width carried alongside each transaction, >=1
//  CNT_W  16  width of the completed-transaction counter
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      input transaction valid
//  in_ready   out  1      block can accept; transfer when in_valid&&in_ready
//  in_a       in   WIDTH  operand A (mux select per bit)
//  in_b       in   WIDTH  operand B (mux data per bit)
//  in_op      in   3      opcode, see BEHAVIOUR
//  in_tag     in   TAG_W  opaque tag, returned unchanged with the result
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer ready; transfer when out_valid&&out_ready
//  out_y      out  WIDTH  result
//  out_tag    out  TAG_W  tag of this result
//  out_zero   out  1      out_y == 0
//  out_par    out  1      XOR-reduce of out_y
//  cnt_clr    in   1      synchronous clear of op_count
//  op_count   out  CNT_W  completed output handshakes, saturating
//  err_op     out  1      sticky: set when an illegal opcode completes; cleared only by reset
// BEHAVIOUR
//  - Opcodes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 PASS_A, 7 illegal.
//    Per bit i, y[i] = a[i] ? d1 : d0. AND {b,0}; OR {1,b}; NAND {~b,1}; NOR {0,~b};
//    XOR {~b,b}; XNOR {b,~b}; PASS_A {1,0}. Illegal: y = 0 and err_op is set when that
//    result handshakes out.
//  - Stage 1 (S1) registers a, b, op, tag on input accept. Stage 2 (S2) registers the mux
//    result, tag, flags and an illegal bit.
//  - Latency: accept at edge N, so out_valid is high after edge N+1 and the result is
//    presented in cycle N+1.
//  - Throughput: one transaction/cycle when out_ready=1. Advance rules:
//    s2_load = s1_valid && (!s2_valid || out_ready); in_ready = !s1_valid || s2_load.
//    in_ready is combinational from out_ready. out_* is stable while out_valid && !out_ready.
//  - Backpressure: with out_ready=0 the pipe holds 2 entries, then in_ready=0. No drop,
//    no duplicate, order preserved.
//  - Simultaneous pop+push in either stage is allowed and leaves occupancy unchanged.
//  - op_count: +1 per output handshake, saturates at 2^CNT_W-1. cnt_clr has priority over
//    a same-cycle handshake (result 0).
//  - Reset (any time, including mid-flight): s1_valid=0, s2_valid=0, out_valid=0, out_y=0,
//    out_tag=0, out_zero=1, out_par=0, op_count=0, err_op=0. In-flight data is discarded.
//    in_ready=1 in the first cycle after reset.
//  - Data registers are don't-care while their valid bit is 0. Outputs still match the
//    reset values until the first load.
// STRUCTURE
//  - Shared package mux_logic_pkg holds the opcode localparams (OP_AND..OP_PASSA, OP_ILL)
//    and a function op_legal(op).
//  - Sub-module mux2_vec #(WIDTH): per-bit 2:1 mux, y = s ? d1 : d0, vector operands.
//    Instantiated once in S2; d1/d0 are chosen by an opcode case.
//  - Top: S1 regs, S2 regs, handshake logic, counter, sticky flag.
// TESTING (WIDTH=8, TAG_W=4)
//  - Truth table: a=8'hF0, b=8'hCC, ops 0..6 back-to-back, out_ready=1. Expect
//    C0, FC, 3F, 03, 3C, C3, F0; out_valid one cycle after each accept; op_count=7.
//  - Illegal op: op=7, a=FF, b=FF, tag=5. Expect y=00, out_zero=1, tag=5, err_op=1 after
//    handshake. err_op stays 1 through later legal ops.
//  - Backpressure: out_ready=0 with 3 pushes. Expect in_ready=0 after 2 accepts and out_y
//    held. Release out_ready: results come out in order, none lost.
//  - Full-rate stream: 20 random ops with out_ready=1. Expect in_ready=1 every cycle and 20
//    results in order vs a model; out_par matches ^y.
//  - Counter: preload via CNT_W=2, 5 handshakes. Expect op_count 1,2,3,3,3. cnt_clr with a
//    handshake in the same cycle gives 0.
//  - Reset mid-flight: rst_n=0 with both stages full. Expect the next cycle to show
//    out_valid=0, op_count=0, err_op=0, in_ready=1, and no stale result ever emitted.

Source files
------------

// File: rtl/mux_logic_pkg.sv
// rtl/mux_logic_pkg.sv - opcode constants and legality helper for the mux logic pipe
package mux_logic_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_NAND  = 3'd2;
  localparam logic [2:0] OP_NOR   = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_PASSA = 3'd6;
  localparam logic [2:0] OP_ILL   = 3'd7;

  function automatic logic op_legal(input logic [2:0] op);
    return op != OP_ILL;
  endfunction

endpackage

// File: rtl/mux2_vec.sv
// rtl/mux2_vec.sv - per-bit 2:1 mux over vector operands, y = s ? d1 : d0
module mux2_vec #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < WIDTH; i++) begin
      y[i] = s[i] ? d1[i] : d0[i];
    end
  end

endmodule

// File: rtl/mux_logic_pipe.sv
// rtl/mux_logic_pipe.sv - two-stage valid/ready pipe applying a mux-built bitwise op
// to two operands, with zero/parity flags, saturating handshake counter and sticky error.
module mux_logic_pipe
  import mux_logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_par,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] op_count,
  output logic             err_op
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_y_q, s2_y_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_par_q, s2_par_d;
  logic             s2_ill_q, s2_ill_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             s2_load;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] mux_d1;
  logic [WIDTH-1:0] mux_d0;
  logic [WIDTH-1:0] mux_y;

  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  // Operand a drives every select; the opcode only picks what sits on the data legs.
  always_comb begin
    mux_d1 = '0;
    mux_d0 = '0;
    case (s1_op_q)
      OP_AND:   begin mux_d1 = s1_b_q;  mux_d0 = '0;      end
      OP_OR:    begin mux_d1 = '1;      mux_d0 = s1_b_q;  end
      OP_NAND:  begin mux_d1 = ~s1_b_q; mux_d0 = '1;      end
      OP_NOR:   begin mux_d1 = '0;      mux_d0 = ~s1_b_q; end
      OP_XOR:   begin mux_d1 = ~s1_b_q; mux_d0 = s1_b_q;  end
      OP_XNOR:  begin mux_d1 = s1_b_q;  mux_d0 = ~s1_b_q; end
      OP_PASSA: begin mux_d1 = '1;      mux_d0 = '0;      end
      default:  begin mux_d1 = '0;      mux_d0 = '0;      end
    endcase
  end

  mux2_vec #(.WIDTH(WIDTH)) u_mux (
    .s  (s1_a_q),
    .d1 (mux_d1),
    .d0 (mux_d0),
    .y  (mux_y)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_op_d    = in_op;
      s1_tag_d   = in_tag;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    s2_y_d     = s2_y_q;
    s2_tag_d   = s2_tag_q;
    s2_zero_d  = s2_zero_q;
    s2_par_d   = s2_par_q;
    s2_ill_d   = s2_ill_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_y_d     = mux_y;
      s2_tag_d   = s1_tag_q;
      s2_zero_d  = (mux_y == '0);
      s2_par_d   = ^mux_y;
      s2_ill_d   = !op_legal(s1_op_q);
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_fire && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    err_d = err_q || (out_fire && s2_ill_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_tag_q   <= '0;
      s2_zero_q  <= 1'b1;
      s2_par_q   <= 1'b0;
      s2_ill_q   <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_y_q     <= s2_y_d;
      s2_tag_q   <= s2_tag_d;
      s2_zero_q  <= s2_zero_d;
      s2_par_q   <= s2_par_d;
      s2_ill_q   <= s2_ill_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_y     = s2_y_q;
  assign out_tag   = s2_tag_q;
  assign out_zero  = s2_zero_q;
  assign out_par   = s2_par_q;
  assign op_count  = cnt_q;
  assign err_op    = err_q;

endmodule

// File: tb/tb_mux_logic_pipe.sv
// tb/tb_mux_logic_pipe.sv - table-driven and directed checks of mux_logic_pipe
module tb_mux_logic_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
  logic [3:0] in_tag;
  logic       out_valid, out_ready;
  logic [7:0] out_y;
  logic [3:0] out_tag;
  logic       out_zero, out_par;
  logic       cnt_clr;
  logic [15:0] op_count;
  logic       err_op;

  logic       c_in_valid, c_in_ready;
  logic [7:0] c_in_a, c_in_b;
  logic [2:0] c_in_op;
  logic [3:0] c_in_tag;
  logic       c_out_valid, c_out_ready;
  logic [7:0] c_out_y;
  logic [3:0] c_out_tag;
  logic       c_out_zero, c_out_par;
  logic       c_cnt_clr;
  logic [1:0] c_op_count;
  logic       c_err_op;

  mux_logic_pipe #(.WIDTH(8), .TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag),
    .out_zero(out_zero), .out_par(out_par),
    .cnt_clr(cnt_clr), .op_count(op_count), .err_op(err_op)
  );

  mux_logic_pipe #(.WIDTH(8), .TAG_W(4), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_a(c_in_a), .in_b(c_in_b),
    .in_op(c_in_op), .in_tag(c_in_tag),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_y(c_out_y), .out_tag(c_out_tag),
    .out_zero(c_out_zero), .out_par(c_out_par),
    .cnt_clr(c_cnt_clr), .op_count(c_op_count), .err_op(c_err_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_y(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return a;
      default: return 8'h00;
    endcase
  endfunction

  typedef struct packed {
    logic [7:0] y;
    logic [3:0] tag;
  } exp_t;

  exp_t exp_q[$];

  // Scoreboard on the falling edge: handshakes seen here complete on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {31'b0, out_valid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          n_pop++;
          chk("sb_y", {24'b0, out_y}, {24'b0, e.y});
          chk("sb_tag", {28'b0, out_tag}, {28'b0, e.tag});
          chk("sb_zero", {31'b0, out_zero}, {31'b0, (e.y == 8'h00)});
          chk("sb_par", {31'b0, out_par}, {31'b0, ^e.y});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{y: model_y(in_op, in_a, in_b), tag: in_tag});
      end
    end
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] tag;
    logic [7:0] y;
    logic       zero;
    logic       par;
  } vec_t;

  vec_t tbl[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [2:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [3:0] tag);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    tbl[0]  = '{3'd0, 8'hF0, 8'hCC, 4'd0, 8'hC0, 1'b0, 1'b0};
    tbl[1]  = '{3'd1, 8'hF0, 8'hCC, 4'd1, 8'hFC, 1'b0, 1'b0};
    tbl[2]  = '{3'd2, 8'hF0, 8'hCC, 4'd2, 8'h3F, 1'b0, 1'b0};
    tbl[3]  = '{3'd3, 8'hF0, 8'hCC, 4'd3, 8'h03, 1'b0, 1'b0};
    tbl[4]  = '{3'd4, 8'hF0, 8'hCC, 4'd4, 8'h3C, 1'b0, 1'b0};
    tbl[5]  = '{3'd5, 8'hF0, 8'hCC, 4'd5, 8'hC3, 1'b0, 1'b0};
    tbl[6]  = '{3'd6, 8'hF0, 8'hCC, 4'd6, 8'hF0, 1'b0, 1'b0};
    tbl[7]  = '{3'd4, 8'h01, 8'h00, 4'd7, 8'h01, 1'b0, 1'b1};
    tbl[8]  = '{3'd0, 8'h0F, 8'hF0, 4'd8, 8'h00, 1'b1, 1'b0};
    tbl[9]  = '{3'd3, 8'h00, 8'hFE, 4'd9, 8'h01, 1'b0, 1'b1};
    tbl[10] = '{3'd2, 8'hFF, 8'hFF, 4'hA, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{3'd6, 8'hA5, 8'h3C, 4'hB, 8'hA5, 1'b0, 1'b0};
    tbl[12] = '{3'd1, 8'h80, 8'h01, 4'hC, 8'h81, 1'b0, 1'b0};
    tbl[13] = '{3'd5, 8'h0F, 8'h0E, 4'hD, 8'hFE, 1'b0, 1'b1};

    rst_n = 1'b0;
    drv(1'b0, 3'd0, 8'h00, 8'h00, 4'd0);
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    c_in_valid = 1'b0; c_in_a = 8'h00; c_in_b = 8'h00; c_in_op = 3'd0; c_in_tag = 4'd0;
    c_out_ready = 1'b1;
    c_cnt_clr = 1'b0;
    step();
    step();

    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_y", {24'b0, out_y}, 32'd0);
    chk("rst_out_tag", {28'b0, out_tag}, 32'd0);
    chk("rst_out_zero", {31'b0, out_zero}, 32'd1);
    chk("rst_out_par", {31'b0, out_par}, 32'd0);
    chk("rst_op_count", {16'b0, op_count}, 32'd0);
    chk("rst_err_op", {31'b0, err_op}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Back-to-back table: entry k is presented two steps after it is driven.
    for (int i = 0; i <= 15; i++) begin
      step();
      if (i == 1) chk("tt_latency_valid", {31'b0, out_valid}, 32'd0);
      if (i >= 2) begin
        chk("tt_valid", {31'b0, out_valid}, 32'd1);
        chk("tt_y", {24'b0, out_y}, {24'b0, tbl[i-2].y});
        chk("tt_tag", {28'b0, out_tag}, {28'b0, tbl[i-2].tag});
        chk("tt_zero", {31'b0, out_zero}, {31'b0, tbl[i-2].zero});
        chk("tt_par", {31'b0, out_par}, {31'b0, tbl[i-2].par});
      end
      if (i == 9) chk("tt_op_count7", {16'b0, op_count}, 32'd7);
      if (i < 14) drv(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag);
      else        drv(1'b0, 3'd0, 8'h00, 8'h00, 4'd0);
      #1;
      chk("tt_in_ready", {31'b0, in_ready}, 32'd1);
    end
    step();
    chk("tt_op_count", {16'b0, op_count}, 32'd14);
    chk("tt_drained", {31'b0, out_valid}, 32'd0);

    // Illegal opcode
    drv(1'b1, 3'd7, 8'hFF, 8'hFF, 4'd5);
    step();
    drv(1'b0, 3'd0, 8'h00, 8'h00, 4'd0);
    step();
    chk("ill_valid", {31'b0, out_valid}, 32'd1);
    chk("ill_y", {24'b0, out_y}, 32'd0);
    chk("ill_zero", {31'b0, out_zero}, 32'd1);
    chk("ill_tag", {28'b0, out_tag}, 32'd5);
    chk("ill_err_before", {31'b0, err_op}, 32'd0);
    step();
    chk("ill_err_after", {31'b0, err_op}, 32'd1);
    chk("ill_op_count", {16'b0, op_count}, 32'd15);
    drv(1'b1, 3'd0, 8'hFF, 8'h0F, 4'd1);
    step();
    drv(1'b0, 3'd0, 8'h00, 8'h00, 4'd0);
    step();
    chk("post_ill_y", {24'b0, out_y}, 32'h0F);
    step();
    chk("err_sticky", {31'b0, err_op}, 32'd1);

    // Backpressure: three pushes against a stalled consumer
    out_ready = 1'b0;
    drv(1'b1, 3'd4, 8'hAA, 8'h0F, 4'd2);
    step();
    drv(1'b1, 3'd1, 8'h11, 8'h22, 4'd3);
    step();
    drv(1'b1, 3'd6, 8'h5A, 8'h00, 4'd4);
    #1;
    chk("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
    chk("bp_y0", {24'b0, out_y}, 32'hA5);
    step();
    chk("bp_in_ready_hold", {31'b0, in_ready}, 32'd0);
    chk("bp_y_held", {24'b0, out_y}, 32'hA5);
    chk("bp_tag_held", {28'b0, out_tag}, 32'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", {31'b0, in_ready}, 32'd1);
    step();
    drv(1'b0, 3'd0, 8'h00, 8'h00, 4'd0);
    chk("bp_y1", {24'b0, out_y}, 32'h33);
    step();
    chk("bp_y2", {24'b0, out_y}, 32'h5A);
    step();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);
    chk("bp_queue_empty", exp_q.size(), 32'd0);

    // Full-rate random stream
    n0 = n_pop;
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, 3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom), 4'($urandom));
      #1;
      chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
      step();
    end
    drv(1'b0, 3'd0, 8'h00, 8'h00, 4'd0);
    step();
    step();
    step();
    chk("stream_count", n_pop - n0, 32'd20);

    // Saturating counter on the 2-bit instance
    for (int i = 0; i <= 7; i++) begin
      step();
      if (i >= 3) chk("sat_count", {30'b0, c_op_count}, (i - 2 > 3) ? 32'd3 : 32'(i - 2));
      c_in_valid = (i < 5);
      c_in_op    = 3'(i % 7);
      c_in_a     = 8'(i * 17);
      c_in_tag   = 4'(i);
    end
    c_in_valid = 1'b1;
    step();
    c_in_valid = 1'b0;
    step();
    chk("clr_pending_valid", {31'b0, c_out_valid}, 32'd1);
    c_cnt_clr = 1'b1;
    step();
    c_cnt_clr = 1'b0;
    chk("clr_priority", {30'b0, c_op_count}, 32'd0);
    chk("clr_handshake_done", {31'b0, c_out_valid}, 32'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    drv(1'b1, 3'd7, 8'h12, 8'h34, 4'd9);
    step();
    drv(1'b1, 3'd1, 8'h56, 8'h78, 4'd6);
    step();
    #1;
    chk("mid_full", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    drv(1'b0, 3'd0, 8'h00, 8'h00, 4'd0);
    step();
    chk("mid_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_op_count", {16'b0, op_count}, 32'd0);
    chk("mid_err_op", {31'b0, err_op}, 32'd0);
    chk("mid_out_y", {24'b0, out_y}, 32'd0);
    chk("mid_out_zero", {31'b0, out_zero}, 32'd1);
    chk("mid_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_stale", {31'b0, out_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
